// File: rtl/data_memory_pl_if.sv
// data_memory_pl_if: request/response bus between the load/store stage and
// the pipelined data memory. master = CPU side, slave = memory side.
interface data_memory_pl_if #(
  parameter int DATA_W = 16,
  parameter int BYTE_W = 8,
  parameter int ADDR_W = 8,
  parameter int TAG_W  = 4
) ();
  localparam int NBE = DATA_W / BYTE_W;

  logic              REQ;
  logic              READY;
  logic              MEMWRITE;
  logic [NBE-1:0]    BE;
  logic [ADDR_W-1:0] Address;
  logic [DATA_W-1:0] WriteData;
  logic [TAG_W-1:0]  TAG;
  logic              STALL;
  logic              PINJ;
  logic              RVALID;
  logic [DATA_W-1:0] ReadData;
  logic [TAG_W-1:0]  RTAG;
  logic              PERR;

  modport master (
    output REQ, MEMWRITE, BE, Address, WriteData, TAG, STALL, PINJ,
    input  READY, RVALID, ReadData, RTAG, PERR
  );

  modport slave (
    input  REQ, MEMWRITE, BE, Address, WriteData, TAG, STALL, PINJ,
    output READY, RVALID, ReadData, RTAG, PERR
  );
endinterface

// File: rtl/data_memory_pl.sv
// data_memory_pl: word-addressed RAM with byte-lane write enables, REQ/READY
// handshake and a READ_LAT-deep tagged read pipeline frozen by STALL.
// Optional per-lane even parity with write-side injection: define
// DATA_MEMORY_PL_PARITY_EN to enable it (PERR is tied low otherwise).
// DATA_W must be a multiple of BYTE_W; READ_LAT must be 1..4.
module data_memory_pl #(
  parameter int DATA_W   = 16,
  parameter int BYTE_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int READ_LAT = 2,
  parameter int TAG_W    = 4
) (
  input logic             CLK,
  input logic             RST,
  data_memory_pl_if.slave bus
);
  localparam int NBE      = DATA_W / BYTE_W;
  localparam int MEM_WORD = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [MEM_WORD];

  logic w_accept, w_wr, w_rd;
  logic [DATA_W-1:0] w_rd_word;
  logic w_rd_perr;

  // Stage-1 pipeline: valid shift register plus data/tag/parity-error payload.
  logic [READ_LAT-1:0]             r_vld_pipe;
  logic [READ_LAT-1:0][DATA_W-1:0] r_dat_pipe;
  logic [READ_LAT-1:0][TAG_W-1:0]  r_tag_pipe;
  logic [READ_LAT-1:0]             r_pe_pipe;

  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  logic [TAG_W-1:0]  r_rtag;
  logic              r_perr;

  // READY drops combinationally under stall or reset, so nothing is accepted then.
  assign bus.READY = !bus.STALL && !RST;
  assign w_accept  = bus.REQ && bus.READY;
  assign w_wr      = w_accept && bus.MEMWRITE;
  assign w_rd      = w_accept && !bus.MEMWRITE;
  assign w_rd_word = r_mem[bus.Address];

`ifdef DATA_MEMORY_PL_PARITY_EN
  // One even-parity bit per byte lane, stored alongside the data array.
  logic [NBE-1:0] r_par [MEM_WORD];
  logic [NBE-1:0] w_lane_par, w_wr_par;

  for (genvar g = 0; g < NBE; g++) begin : g_lane_par
    assign w_lane_par[g] = ^w_rd_word[g*BYTE_W +: BYTE_W];
    assign w_wr_par[g]   = (^bus.WriteData[g*BYTE_W +: BYTE_W]) ^ bus.PINJ;
  end

  assign w_rd_perr = |(w_lane_par ^ r_par[bus.Address]);

  // Parity bits commit on the same edge and with the same lane enables as data.
  always_ff @(posedge CLK) begin
    if (w_wr) begin
      for (int i = 0; i < NBE; i++)
        if (bus.BE[i]) r_par[bus.Address][i] <= w_wr_par[i];
    end
  end
`else
  logic w_unused_pinj;
  assign w_unused_pinj = bus.PINJ;
  assign w_rd_perr     = 1'b0;
`endif

  // Power-up image of the array (loaded as RAM init content); reset never touches it.
  initial begin
    for (int a = 0; a < MEM_WORD; a++) r_mem[a] = '0;
    r_mem[0] = DATA_W'(16'h1234);
    r_mem[1] = DATA_W'(16'h5678);
`ifdef DATA_MEMORY_PL_PARITY_EN
    for (int a = 0; a < MEM_WORD; a++)
      for (int i = 0; i < NBE; i++)
        r_par[a][i] = ^r_mem[a][i*BYTE_W +: BYTE_W];
`endif
  end

  // Byte-lane write: enabled lanes commit at the accept edge, others keep their value.
  always_ff @(posedge CLK) begin
    if (w_wr) begin
      for (int i = 0; i < NBE; i++)
        if (bus.BE[i]) r_mem[bus.Address][i*BYTE_W +: BYTE_W] <= bus.WriteData[i*BYTE_W +: BYTE_W];
    end
  end

  // Read pipeline: capture at accept, shift when not stalled, register stage READ_LAT to outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_vld_pipe <= '0;
      r_dat_pipe <= '0;
      r_tag_pipe <= '0;
      r_pe_pipe  <= '0;
      r_rvalid   <= 1'b0;
      r_rdata    <= '0;
      r_rtag     <= '0;
      r_perr     <= 1'b0;
    end else if (!bus.STALL) begin
      r_vld_pipe[0] <= w_rd;
      if (w_rd) begin
        r_dat_pipe[0] <= w_rd_word;
        r_tag_pipe[0] <= bus.TAG;
        r_pe_pipe[0]  <= w_rd_perr;
      end
      for (int s = 1; s < READ_LAT; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        r_dat_pipe[s] <= r_dat_pipe[s-1];
        r_tag_pipe[s] <= r_tag_pipe[s-1];
        r_pe_pipe[s]  <= r_pe_pipe[s-1];
      end
      r_rvalid <= r_vld_pipe[READ_LAT-1];
      r_perr   <= r_vld_pipe[READ_LAT-1] & r_pe_pipe[READ_LAT-1];
      if (r_vld_pipe[READ_LAT-1]) begin
        r_rdata <= r_dat_pipe[READ_LAT-1];
        r_rtag  <= r_tag_pipe[READ_LAT-1];
      end
    end
  end

  assign bus.RVALID   = r_rvalid;
  assign bus.ReadData = r_rdata;
  assign bus.RTAG     = r_rtag;
`ifdef DATA_MEMORY_PL_PARITY_EN
  assign bus.PERR     = r_perr;
`else
  assign bus.PERR     = 1'b0;
  logic w_unused_perr;
  assign w_unused_perr = r_perr;
`endif

endmodule

// File: tb/tb_data_memory_pl.sv
// tb_data_memory_pl: directed + randomized bench for data_memory_pl with a
// cycle-level reference model (array + queue of due reads).
module tb_data_memory_pl;
  localparam int DATA_W = 16, BYTE_W = 8, ADDR_W = 8, READ_LAT = 2, TAG_W = 4;
`ifdef DATA_MEMORY_PL_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_memory_pl_if #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W), .TAG_W(TAG_W)) bus ();

  data_memory_pl #(.DATA_W(DATA_W), .BYTE_W(BYTE_W), .ADDR_W(ADDR_W),
                   .READ_LAT(READ_LAT), .TAG_W(TAG_W)) dut (
    .CLK(clk), .RST(rst), .bus(bus)
  );

  int checks = 0, failures = 0;

  typedef struct { int due; logic [15:0] d; logic [3:0] t; logic pe; } rd_t;
  rd_t         q[$];
  logic [15:0] mdl  [256];
  logic [1:0]  minj [256];
  int          ecnt = 0;
  logic        ev = 1'b0, ep = 1'b0;
  logic [15:0] ed = '0;
  logic [3:0]  et = '0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic perr_of(input logic [7:0] a);
    return PAR & (|minj[a]);
  endfunction

  // One clock: drive inputs, check READY, advance model at the edge, check outputs.
  task automatic cyc(input bit req, input bit we, input logic [1:0] be, input logic [7:0] a,
                     input logic [15:0] wd, input logic [3:0] tg, input bit st, input bit pj);
    rd_t r;
    bus.REQ = req; bus.MEMWRITE = we; bus.BE = be; bus.Address = a;
    bus.WriteData = wd; bus.TAG = tg; bus.STALL = st; bus.PINJ = pj;
    #1 chk("ready", bus.READY, (!st && !rst));
    @(posedge clk);
    if (rst) begin
      q.delete(); ev = 0; ed = 0; et = 0; ep = 0;
    end else if (!st) begin
      ecnt++;
      if (q.size() > 0 && q[0].due == ecnt) begin
        r = q.pop_front(); ev = 1; ed = r.d; et = r.t; ep = r.pe;
      end else begin
        ev = 0; ep = 0;
      end
      if (req && we) begin
        for (int i = 0; i < 2; i++) begin
          if (be[i]) begin mdl[a][i*8 +: 8] = wd[i*8 +: 8]; minj[a][i] = pj; end
        end
      end else if (req) begin
        q.push_back('{ecnt + READ_LAT, mdl[a], tg, perr_of(a)});
      end
    end
    #1;
    chk("rvalid", bus.RVALID, ev);
    chk("rdata", bus.ReadData, ed);
    chk("rtag", bus.RTAG, et);
    chk("perr", bus.PERR, ep);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 2'b00, 8'h00, 16'h0, 4'h0, 0, 0);
  endtask

  task automatic rd(input logic [7:0] a, input logic [3:0] tg);
    cyc(1, 0, 2'b00, a, 16'h0, tg, 0, 0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] wd, input logic [1:0] be, input bit pj);
    cyc(1, 1, be, a, wd, 4'h0, 0, pj);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 256; a++) begin mdl[a] = 16'h0; minj[a] = 2'b00; end
    mdl[0] = 16'h1234; mdl[1] = 16'h5678;
    bus.REQ = 0; bus.MEMWRITE = 0; bus.BE = '0; bus.Address = '0;
    bus.WriteData = '0; bus.TAG = '0; bus.STALL = 0; bus.PINJ = 0;
    @(posedge clk); #1;

    // reset state, REQ held high must not be accepted
    cyc(1, 0, 2'b00, 8'h00, 16'h0, 4'h1, 0, 0);
    cyc(1, 0, 2'b00, 8'h01, 16'h0, 4'h2, 0, 0);
    rst = 0;

    // power-up contents, back-to-back reads
    rd(8'h00, 4'h3);
    rd(8'h01, 4'h4);
    idle(1);
    chk("pwr_w0_v", bus.RVALID, 1'b1); chk("pwr_w0_d", bus.ReadData, 16'h1234); chk("pwr_w0_t", bus.RTAG, 4'h3);
    idle(1);
    chk("pwr_w1_v", bus.RVALID, 1'b1); chk("pwr_w1_d", bus.ReadData, 16'h5678); chk("pwr_w1_t", bus.RTAG, 4'h4);
    idle(1);
    chk("pulse_end", bus.RVALID, 1'b0);

    // byte-lane merge
    wr(8'h05, 16'hABCD, 2'b11, 0);
    wr(8'h05, 16'h0012, 2'b01, 0);
    rd(8'h05, 4'h5);
    idle(2);
    chk("be_merge", bus.ReadData, 16'hAB12);

    // read right after write
    wr(8'h07, 16'h55AA, 2'b11, 0);
    rd(8'h07, 4'h6);
    idle(2);
    chk("raw_d", bus.ReadData, 16'h55AA);

    // stall freezes pipeline; REQ under stall ignored
    rd(8'h00, 4'h9);
    cyc(1, 0, 2'b00, 8'h01, 16'h0, 4'hA, 1, 0);
    cyc(1, 1, 2'b11, 8'h00, 16'hDEAD, 4'h0, 1, 0);
    cyc(0, 0, 2'b00, 8'h00, 16'h0, 4'h0, 1, 0);
    idle(2);
    chk("stall_v", bus.RVALID, 1'b1); chk("stall_d", bus.ReadData, 16'h1234); chk("stall_t", bus.RTAG, 4'h9);
    cyc(0, 0, 2'b00, 8'h00, 16'h0, 4'h0, 1, 0);
    chk("stall_hold", bus.RVALID, 1'b1);
    idle(1);

    // BE=0 no-op write, top-of-range address
    wr(8'h05, 16'hFFFF, 2'b00, 0);
    wr(8'hFF, 16'hBEEF, 2'b11, 0);
    rd(8'h05, 4'h1);
    rd(8'hFF, 4'h2);
    idle(1);
    chk("be0_noop", bus.ReadData, 16'hAB12);
    idle(1);
    chk("top_addr", bus.ReadData, 16'hBEEF);
    idle(1);

    // async reset mid-cycle discards in-flight reads
    rd(8'h00, 4'h7);
    rd(8'h01, 4'h8);
    idle(1);
    #2 rst = 1;
    #1;
    chk("arst_v", bus.RVALID, 1'b0); chk("arst_d", bus.ReadData, 16'h0);
    chk("arst_t", bus.RTAG, 4'h0); chk("arst_p", bus.PERR, 1'b0);
    q.delete(); ev = 0; ed = 0; et = 0; ep = 0;
    cyc(1, 1, 2'b11, 8'h00, 16'hFFFF, 4'h0, 0, 0);
    cyc(0, 0, 2'b00, 8'h00, 16'h0, 4'h0, 0, 0);
    rst = 0;
    idle(4);
    rd(8'h00, 4'hC);
    idle(2);
    chk("arst_w0", bus.ReadData, 16'h1234);

    // parity inject (PERR must stay 0 when the feature is compiled out)
    wr(8'h09, 16'h00FF, 2'b01, 1);
    rd(8'h09, 4'hD);
    idle(2);
    chk("pinj_v", bus.RVALID, 1'b1); chk("pinj_perr", bus.PERR, PAR);
    idle(1);
    chk("perr_qual", bus.PERR, 1'b0);
    wr(8'h09, 16'h00FF, 2'b01, 0);
    rd(8'h09, 4'hE);
    idle(2);
    chk("pclr_perr", bus.PERR, 1'b0);

    // randomized traffic with stalls
    for (int n = 0; n < 400; n++) begin
      cyc(($urandom % 4) != 0, $urandom % 2, 2'($urandom), 8'($urandom_range(0, 15)),
          16'($urandom), 4'($urandom), ($urandom % 5) == 0, $urandom % 2);
    end
    idle(READ_LAT + 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
